max_reduce_serial_uint: RTL and testbench
=========================================

# max_reduce_serial_uint

Bit-serial unsigned max-reduction stage: accepts a frame of WIDTH-bit unsigned words over a valid/ready stream and returns the largest word and its position once the frame ends. It consumes the greater-than decision of a borrow-chain comparator. That comparator is evaluated one bit per cycle, LSB first, through a single borrow flop, which matches the bit-serial style of the team's PIM-mapped arithmetic. It sits downstream of operand fetch and feeds result write-back.

## Interface
- `WIDTH`, default 32, operand width in bits (≥1).
- `IDX_W`, default 8, width of the word-position counter and `out_idx`.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `in_valid` input 1 — input word valid.
- `in_ready` output 1 — block can accept a word.
- `in_data` input WIDTH — unsigned operand.
- `in_last` input 1 — qualifies `in_data` as the final word of the frame.
- `out_valid` output 1 — result valid.
- `out_ready` input 1 — downstream accepts the result.
- `out_max` output WIDTH — maximum of the frame.
- `out_idx` output IDX_W — zero-based position of the maximum. Present only with `MAX_REDUCE_INDEX_EN`.

## Operation
- **States:** ACCEPT, CMP, UPDATE, DONE. Reset enters ACCEPT with the `first` flag set.
- **Input handshake:** occurs when `in_valid & in_ready`. `in_ready` = (state==ACCEPT) & `rst_n`.
- **ACCEPT, first word:**
  - Load `max_reg` ← `in_data`, `idx_reg` ← 0, `cnt` ← 1; clear `first`.
  - Go to DONE if `in_last`, else stay in ACCEPT.
- **ACCEPT, later word:**
  - Load `cand_reg` ← `in_data`, latch `last_reg` ← `in_last`, clear the borrow flop.
  - Go to CMP.
- **CMP:** lasts exactly WIDTH cycles, bit i = 0..WIDTH-1.
  - Each cycle: `b` ← (~max[i] & cand[i]) | (~(max[i]^cand[i]) & b), computing the borrow of max − cand.
  - A bit counter of width $clog2(WIDTH+1) selects the bit. Working copies shift right; `max_reg` itself is unchanged during CMP.
- **UPDATE:**
  - If `b`==1 (cand > max, strict): `max_reg` ← cand and `idx_reg` ← `cnt`.
  - Ties keep the earlier word.
  - `cnt` ← `cnt`+1, modulo 2^IDX_W (wraps, so indices above 2^IDX_W−1 alias; no error flag).
  - Go to DONE if `last_reg`, else ACCEPT.
- **DONE:**
  - `out_valid`=1; `out_max`/`out_idx` driven from registers and held stable until `out_ready`.
  - On `out_ready`: go to ACCEPT, set `first`.
- **Reset values:**
  - Asynchronous; no partial frame survives reset.
  - `out_valid`=0, `out_max`=0, `out_idx`=0, `in_ready`=0 while `rst_n` low.
  - All internal registers cleared, `first`=1.

## Timing
- **First word, handshake at cycle t:**
  - Not last: `in_ready`=1 again at t+1.
  - Last: `out_valid`=1 at t+1.
- **Later word, handshake at t:**
  - CMP spans t+1..t+WIDTH, UPDATE at t+WIDTH+1.
  - At t+WIDTH+2, either ACCEPT (`in_ready`=1) or DONE (`out_valid`=1).
  - Throughput: one word per WIDTH+2 cycles after the first.
- **Backpressure:**
  - `in_ready`=0 throughout CMP, UPDATE and DONE.
  - `in_valid` without `in_ready` has no effect; the source holds `in_data`/`in_last`.
- **DONE exit:** `out_ready` high on the first DONE cycle gives a one-cycle `out_valid`. `in_ready`=1 the next cycle; a new frame is never accepted in the same cycle the result is taken.
- **Reset mid-frame:** `rst_n` falling in any state forces ACCEPT/reset values immediately. The first handshake after release starts a new frame.

## Configuration
- `MAX_REDUCE_INDEX_EN` defined:
  - `idx_reg`, `cnt` and the `out_idx` port exist and behave as above.
- `MAX_REDUCE_INDEX_EN` undefined:
  - `out_idx`, `idx_reg` and `cnt` are removed.
  - `out_max`, handshake and timing are identical.

## Test plan
- **Basic max:** WIDTH=8, frame 3, 9, 5(last) → `out_max`=9, `out_idx`=1. `out_valid` rises 2·(WIDTH+2)+1 = 21 cycles after the first handshake when `in_valid` is held continuously.
- **Ties:** frame 7, 7, 7(last) → `out_max`=7, `out_idx`=0 (strict greater-than).
- **Single word:** 0xA5 with `in_last` → `out_valid`=1 the next cycle, `out_max`=0xA5, `out_idx`=0.
- **Extremes:**
  - 0x00, 0xFF, 0xFE(last) → 0xFF, idx 1.
  - 0xFF, 0x00(last) → 0xFF, idx 0.
- **Output backpressure:** hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `out_max` stable and `in_ready`=0. Raise `out_ready` → the next frame 1, 2(last) yields `out_max`=2.
- **Reset mid-CMP:** assert `rst_n`=0 during CMP of word 2 → `out_valid`=0 and `out_max`=0 immediately. After release, frame 4(last) → `out_max`=4, `out_idx`=0.

Source files
------------

// File: rtl/max_reduce_serial_uint.sv
// max_reduce_serial_uint: bit-serial unsigned max reduction over a valid/ready frame (MAX_REDUCE_INDEX_EN adds out_idx)
module max_reduce_serial_uint #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max
`ifdef MAX_REDUCE_INDEX_EN
  ,
  output logic [IDX_W-1:0] out_idx
`endif
);
  localparam int BW = $clog2(WIDTH + 1);
  if (WIDTH < 1 || IDX_W < 1) begin : g_bad_params
    $error("max_reduce_serial_uint: WIDTH and IDX_W must be at least 1");
  end
  typedef enum logic [1:0] {ACCEPT, CMP, UPDATE, DONE} state_t;
  state_t state, state_nx;
  logic [BW-1:0] bcnt;
  logic [WIDTH-1:0] max_reg, cand_reg, wmax, wcand;
  logic first, last_reg, b;
  logic in_hs, cmp_end;
`ifdef MAX_REDUCE_INDEX_EN
  logic [IDX_W-1:0] idx_reg, cnt;
  assign out_idx = idx_reg;
`endif
  assign in_ready  = (state == ACCEPT) & rst_n;
  assign out_valid = state == DONE;
  assign out_max   = max_reg;
  assign in_hs     = in_valid & in_ready;
  assign cmp_end   = bcnt == BW'(WIDTH - 1);
  // state register, forced back to ACCEPT the moment reset asserts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACCEPT;
    else state <= state_nx;
  // next state: first word only seeds the max, later words run a WIDTH-cycle compare
  always_comb begin
    state_nx = state;
    case (state)
      ACCEPT:  state_nx = in_hs ? (first ? (in_last ? DONE : ACCEPT) : CMP) : ACCEPT;
      CMP:     state_nx = cmp_end ? UPDATE : CMP;
      UPDATE:  state_nx = last_reg ? DONE : ACCEPT;
      DONE:    state_nx = out_ready ? ACCEPT : DONE;
      default: state_nx = ACCEPT;
    endcase
  end
  // datapath: LSB-first borrow chain of max - cand; a final borrow means cand is strictly larger
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      max_reg  <= '0;
      cand_reg <= '0;
      wmax     <= '0;
      wcand    <= '0;
      bcnt     <= '0;
      b        <= 1'b0;
      last_reg <= 1'b0;
      first    <= 1'b1;
`ifdef MAX_REDUCE_INDEX_EN
      idx_reg  <= '0;
      cnt      <= '0;
`endif
    end else begin
      if (in_hs && first) begin
        max_reg <= in_data;
        first   <= 1'b0;
`ifdef MAX_REDUCE_INDEX_EN
        idx_reg <= '0;
        cnt     <= IDX_W'(1);
`endif
      end
      if (in_hs && !first) begin
        cand_reg <= in_data;
        wcand    <= in_data;
        wmax     <= max_reg;
        last_reg <= in_last;
        b        <= 1'b0;
        bcnt     <= '0;
      end
      if (state == CMP) begin
        b     <= (~wmax[0] & wcand[0]) | (~(wmax[0] ^ wcand[0]) & b);
        wmax  <= wmax >> 1;
        wcand <= wcand >> 1;
        bcnt  <= bcnt + 1'b1;
      end
      if (state == UPDATE) begin
        if (b) max_reg <= cand_reg;
`ifdef MAX_REDUCE_INDEX_EN
        if (b) idx_reg <= cnt;
        cnt <= cnt + 1'b1;
`endif
      end
      if (state == DONE && out_ready) first <= 1'b1;
    end
endmodule

// File: tb/tb_max_reduce_serial_uint.sv
// tb_max_reduce_serial_uint: scoreboard bench for max_reduce_serial_uint with directed frames
module tb_max_reduce_serial_uint;
  localparam int W  = 8;
  localparam int IW = 8;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [W-1:0] in_data = '0, out_max;
`ifdef MAX_REDUCE_INDEX_EN
  logic [IW-1:0] out_idx;
`endif
  typedef struct packed {logic [W-1:0] m; logic [IW-1:0] i;} exp_t;
  typedef logic [W-1:0] frame_t [4];
  exp_t q[$];
  int checks = 0, passes = 0, cyc = 0, rise_cyc = -1, hs_cyc = 0;
  logic pv = 0;

  max_reduce_serial_uint #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max)
`ifdef MAX_REDUCE_INDEX_EN
    , .out_idx(out_idx)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !pv) rise_cyc = cyc;
    pv = out_valid;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_out", {24'b0, out_max}, 32'hdead);
      else begin
        e = q.pop_front();
        check("out_max", {24'b0, out_max}, {24'b0, e.m});
`ifdef MAX_REDUCE_INDEX_EN
        check("out_idx", {24'b0, out_idx}, {24'b0, e.i});
`endif
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic l, output int hc);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 1);
    hc = cyc;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic run_frame(input frame_t w, input int n, input logic [W-1:0] em, input logic [IW-1:0] ei);
    exp_t e;
    int hc;
    e.m = em; e.i = ei;
    q.push_back(e);
    for (int i = 0; i < n; i++) begin
      send_word(w[i], i == n - 1, hc);
      if (i == 0) hs_cyc = hc;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int hc;
    int n;
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_out_max", {24'b0, out_max}, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    run_frame('{8'h03, 8'h09, 8'h05, 8'h00}, 3, 8'h09, 8'd1);
    drain();
    check("lat_basic", rise_cyc - hs_cyc, 21);
    run_frame('{8'h07, 8'h07, 8'h07, 8'h00}, 3, 8'h07, 8'd0);
    run_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 1, 8'hA5, 8'd0);
    drain();
    check("lat_single", rise_cyc - hs_cyc, 1);
    run_frame('{8'h00, 8'hFF, 8'hFE, 8'h00}, 3, 8'hFF, 8'd1);
    run_frame('{8'hFF, 8'h00, 8'h00, 8'h00}, 2, 8'hFF, 8'd0);
    run_frame('{8'h80, 8'h81, 8'h7F, 8'h81}, 4, 8'h81, 8'd1);
    drain();
    out_ready = 0;
    run_frame('{8'h42, 8'h17, 8'h00, 8'h00}, 2, 8'h42, 8'd0);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, out_valid}, 1);
      check("bp_out_max", {24'b0, out_max}, 32'h42);
      check("bp_in_ready", {31'b0, in_ready}, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    drain();
    run_frame('{8'h01, 8'h02, 8'h00, 8'h00}, 2, 8'h02, 8'd1);
    drain();
    send_word(8'h10, 0, hc);
    send_word(8'h30, 0, hc);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    check("midrst_out_max", {24'b0, out_max}, 0);
    check("midrst_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk); #1 rst_n = 1;
    run_frame('{8'h04, 8'h00, 8'h00, 8'h00}, 1, 8'h04, 8'd0);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end
endmodule
